// File: rtl/iomem_fabric.sv
// rtl/iomem_fabric.sv - block-bus fabric: region decode, response latency, decode error, machine timer
module iomem_fabric #(
    parameter int                        BLOCK_SIZE  = 128,
    parameter int                        NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h8000_0000, 32'h2000_0000},
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK = {32'h000f_ffff, 32'h0000_000f},
    parameter logic [NUM_REGIONS*8-1:0]  REGION_LAT  = {8'd16, 8'd2},
    parameter logic [31:0]               TIMER_BASE  = 32'h3000_0000,
    localparam int                       NB          = BLOCK_SIZE / 8
) (
    input  logic                              clk_o,
    input  logic                              rst_n,
    input  logic                              m_valid_i,
    input  logic [31:0]                       m_addr_i,
    input  logic [NB-1:0]                     m_wstrb_i,
    input  logic [BLOCK_SIZE-1:0]             m_wdata_i,
    output logic                              m_ready_o,
    output logic [BLOCK_SIZE-1:0]             m_rdata_o,
    output logic                              m_err_o,
    output logic [NUM_REGIONS-1:0]            s_sel_o,
    output logic [NB-1:0]                     s_wstrb_o,
    output logic                              s_rd_en_o,
    output logic [BLOCK_SIZE-1:0]             s_wdata_o,
    input  logic [NUM_REGIONS*BLOCK_SIZE-1:0] s_rdata_i,
    output logic [63:0]                       timer_o,
    output logic                              timer_irq_o
);
    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
    typedef enum logic [1:0] {K_REGION, K_TIMER, K_UNMAP} kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [RW-1:0]   idx_q, idx_d;
    logic [1:0]      word_q, word_d;
    logic            rd_q, rd_d;
    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            irq_q;

    logic            accept;
    logic            hit_timer;
    logic            hit_region;
    logic [RW-1:0]   hit_idx;
    logic [7:0]      hit_lat;
    logic            region_acc;
    logic [15:0]     tw_strb;
    logic [127:0]    tw_data;
    logic            tw_en;
    int              lane_off;
    logic [127:0]    timer_rd;

    assign accept = rst_n && (state_q == ST_IDLE) && m_valid_i;

    // Regions are scanned high to low so the lowest-index match is the one left standing
    always_comb begin
        hit_timer  = ((m_addr_i & ~32'hF) == TIMER_BASE);
        hit_region = 1'b0;
        hit_idx    = '0;
        hit_lat    = 8'd0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((m_addr_i & ~REGION_MASK[r*32 +: 32]) == REGION_BASE[r*32 +: 32]) begin
                hit_region = 1'b1;
                hit_idx    = RW'(r);
                hit_lat    = REGION_LAT[r*8 +: 8];
            end
        end
    end

    assign region_acc = accept && !hit_timer && hit_region;
    assign s_sel_o    = region_acc ? (NUM_REGIONS'(1) << hit_idx) : '0;
    assign s_wstrb_o  = region_acc ? m_wstrb_i : '0;
    assign s_rd_en_o  = region_acc && (m_wstrb_i == '0);
    assign s_wdata_o  = m_wdata_i;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d = m_addr_i[3:2];
                    rd_d   = (m_wstrb_i == '0);
                    idx_d  = hit_idx;
                    if (hit_timer) begin
                        kind_d = K_TIMER;
                        cnt_d  = 8'd0;
                    end else if (hit_region) begin
                        kind_d = K_REGION;
                        cnt_d  = (hit_lat == 8'd0) ? 8'd0 : hit_lat - 8'd1;
                    end else begin
                        kind_d = K_UNMAP;
                        cnt_d  = 8'd0;
                    end
                    // A single-cycle latency skips WAIT so RESP lands in T+1
                    state_d = (cnt_d == 8'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= K_UNMAP;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            word_q  <= 2'd0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            rd_q    <= rd_d;
        end
    end

    // Map bus lanes onto the 16-byte {mtimecmp, mtime} window
    always_comb begin
        tw_strb  = '0;
        tw_data  = '0;
        lane_off = (NB >= 16) ? 0 : (int'(m_addr_i[3:0]) & ~(NB - 1) & 15);
        for (int l = 0; l < NB; l++) begin
            if (l < 16) begin
                tw_strb[(l + lane_off) & 15]         = m_wstrb_i[l];
                tw_data[((l + lane_off) & 15)*8 +: 8] = m_wdata_i[l*8 +: 8];
            end
        end
    end

    assign tw_en = accept && hit_timer;

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        for (int b = 0; b < 8; b++) begin
            if (tw_en && tw_strb[b])
                mtime_d[b*8 +: 8] = tw_data[b*8 +: 8];
            if (tw_en && tw_strb[b+8])
                mtimecmp_d[b*8 +: 8] = tw_data[(b+8)*8 +: 8];
        end
        if (!(tw_en && (tw_strb[7:0] != 8'd0)))
            mtime_d = mtime_q + 64'd1;
    end

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_o     = mtime_q;
    assign timer_irq_o = irq_q;
    assign timer_rd    = {mtimecmp_q, mtime_q} >> {word_q, 5'd0};
    assign m_ready_o   = rst_n && (state_q == ST_RESP);
    assign m_err_o     = m_ready_o && (kind_q == K_UNMAP);

    always_comb begin
        m_rdata_o = '0;
        if (m_ready_o && rd_q) begin
            case (kind_q)
                K_REGION: m_rdata_o = s_rdata_i[idx_q*BLOCK_SIZE +: BLOCK_SIZE];
                K_TIMER:  m_rdata_o = BLOCK_SIZE'(timer_rd);
                default:  m_rdata_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_iomem_fabric.sv
// tb/tb_iomem_fabric.sv - self-checking bench for iomem_fabric with a cycle-level reference model
module tb_iomem_fabric;
    localparam logic [127:0] SLV0 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    localparam logic [127:0] SLV1 = 128'hcafe_f00d_dead_beef_1234_5678_9abc_def0;
    localparam logic [31:0]  RBASE [2] = '{32'h2000_0000, 32'h8000_0000};
    localparam logic [31:0]  RMASK [2] = '{32'h0000_000f, 32'h000f_ffff};
    localparam int           RLAT  [2] = '{2, 16};

    logic         clk_o, rst_n, m_valid_i, m_ready_o, m_err_o, s_rd_en_o, timer_irq_o;
    logic [31:0]  m_addr_i;
    logic [15:0]  m_wstrb_i, s_wstrb_o;
    logic [127:0] m_wdata_i, m_rdata_o, s_wdata_o;
    logic [1:0]   s_sel_o;
    logic [255:0] s_rdata_i;
    logic [63:0]  timer_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    assign s_rdata_i = {SLV1, SLV0};

    iomem_fabric dut (
        .clk_o(clk_o), .rst_n(rst_n), .m_valid_i(m_valid_i), .m_addr_i(m_addr_i),
        .m_wstrb_i(m_wstrb_i), .m_wdata_i(m_wdata_i), .m_ready_o(m_ready_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .s_sel_o(s_sel_o), .s_wstrb_o(s_wstrb_o),
        .s_rd_en_o(s_rd_en_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
        .timer_o(timer_o), .timer_irq_o(timer_irq_o)
    );

    initial clk_o = 1'b0;
    always #5 clk_o = ~clk_o;
    always @(posedge clk_o) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // kind: 0 region, 1 timer, 2 unmapped
    function automatic void decode(input logic [31:0] a, output int kind, output int rg, output int l);
        kind = 2; rg = 0; l = 1;
        if ((a & ~32'hF) == 32'h3000_0000) kind = 1;
        else
            for (int r = 0; r < 2; r++)
                if (kind == 2 && (a & ~RMASK[r]) == RBASE[r]) begin
                    kind = 0; rg = r; l = (RLAT[r] == 0) ? 1 : RLAT[r];
                end
    endfunction

    bit           mvalid = 0;
    logic [63:0]  mt, mc;
    bit           irq_e, pend, prd;
    int           due, next_free, pkind, preg, pword;

    always @(negedge clk_o) begin : model
        int kind, rg, l;
        bit acc, rdy;
        logic [127:0] tw, exp_rd;
        decode(m_addr_i, kind, rg, l);
        acc = rst_n && m_valid_i && (cyc >= next_free);
        rdy = rst_n && pend && (cyc == due);
        if (mvalid) begin
            chk("ready", m_ready_o, rdy);
            chk("err", m_err_o, rdy && pkind == 2);
            if (rdy && prd) begin
                exp_rd = (pkind == 0) ? (preg == 0 ? SLV0 : SLV1) :
                         (pkind == 1) ? ({mc, mt} >> (pword * 32)) : 128'd0;
                chk("rdata", m_rdata_o, exp_rd);
            end
            chk("sel", s_sel_o, (acc && kind == 0) ? (2'b01 << rg) : 2'b00);
            chk("s_wstrb", s_wstrb_o, (acc && kind == 0) ? m_wstrb_i : 16'h0);
            chk("rd_en", s_rd_en_o, acc && kind == 0 && m_wstrb_i == 16'h0);
            chk("s_wdata", s_wdata_o, m_wdata_i);
            chk("timer", timer_o, mt);
            chk("irq", timer_irq_o, irq_e);
        end
        if (!rst_n) begin
            mt = 64'd0; mc = '1; irq_e = 0; pend = 0; next_free = cyc + 1; mvalid = 1;
        end else if (mvalid) begin
            irq_e = (mt >= mc);
            if (rdy) pend = 0;
            if (acc) begin
                pend = 1; due = cyc + l; next_free = due + 1;
                pkind = kind; preg = rg; prd = (m_wstrb_i == 16'h0); pword = int'(m_addr_i[3:2]);
            end
            tw = {mc, mt};
            if (acc && kind == 1)
                for (int b = 0; b < 16; b++)
                    if (m_wstrb_i[b]) tw[b*8 +: 8] = m_wdata_i[b*8 +: 8];
            mc = tw[127:64];
            mt = (acc && kind == 1 && m_wstrb_i[7:0] != 8'h0) ? tw[63:0] : mt + 64'd1;
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [15:0] ws, input logic [127:0] wd,
                          output int lat, output logic [127:0] rd, output logic er,
                          output logic [1:0] sel, output logic [15:0] sws, output logic rden);
        @(posedge clk_o); #1;
        m_valid_i = 1; m_addr_i = a; m_wstrb_i = ws; m_wdata_i = wd;
        lat = -1; rd = '0; er = 0; sel = 0; sws = 0; rden = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_o);
            if (n == 0) begin sel = s_sel_o; sws = s_wstrb_o; rden = s_rd_en_o; end
            if (m_ready_o) begin lat = n; rd = m_rdata_o; er = m_err_o; break; end
            @(posedge clk_o); #1;
            m_valid_i = 0; m_wstrb_i = 0;
        end
    endtask

    initial begin
        int lat, seen;
        logic [127:0] rd;
        logic er, rden;
        logic [1:0] sel;
        logic [15:0] sws;
        rst_n = 0; m_valid_i = 0; m_addr_i = 0; m_wstrb_i = 0; m_wdata_i = 0;
        repeat (3) @(posedge clk_o);
        #1 rst_n = 1;
        @(negedge clk_o);
        chk("rst_timer", timer_o, 0);
        chk("rst_irq", timer_irq_o, 0);
        chk("rst_ready", m_ready_o, 0);

        do_req(32'h3000_0008, 16'hFF00, {64'd100, 64'hdead}, lat, rd, er, sel, sws, rden);
        chk("cmp_wr_lat", lat, 1);
        seen = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_o);
            if (timer_irq_o) begin seen = 1; chk("irq_at_mtime", timer_o, 101); break; end
        end
        chk("irq_rose", seen, 1);
        do_req(32'h3000_0000, 16'h0, 128'h0, lat, rd, er, sel, sws, rden);
        chk("tmr_rd_lat", lat, 1);
        do_req(32'h3000_0008, 16'h0, 128'h0, lat, rd, er, sel, sws, rden);
        chk("tmr_rd_cmp", rd, 128'd100);

        do_req(32'h8000_0040, 16'h0, 128'h0, lat, rd, er, sel, sws, rden);
        chk("r1_lat", lat, 16); chk("r1_sel", sel, 2'b10); chk("r1_rden", rden, 1);
        chk("r1_rdata", rd, SLV1); chk("r1_err", er, 0);

        do_req(32'h2000_0004, 16'h00F0, {4{32'h5a5a_a5a5}}, lat, rd, er, sel, sws, rden);
        chk("r0w_lat", lat, 2); chk("r0w_wstrb", sws, 16'h00F0);
        chk("r0w_sel", sel, 2'b01); chk("r0w_rden", rden, 0);

        do_req(32'h2000_000C, 16'h0, 128'h0, lat, rd, er, sel, sws, rden);
        chk("r0r_lat", lat, 2); chk("r0r_rdata", rd, SLV0);

        do_req(32'h1000_0000, 16'h0, 128'h0, lat, rd, er, sel, sws, rden);
        chk("um_lat", lat, 1); chk("um_err", er, 1); chk("um_rdata", rd, 0); chk("um_sel", sel, 0);

        @(posedge clk_o); #1;
        m_valid_i = 1; m_addr_i = 32'h1000_0000; m_wstrb_i = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk_o);
            if (m_ready_o) seen++;
            @(posedge clk_o); #1;
        end
        m_valid_i = 0;
        chk("b2b_count", seen, 3);

        do_req(32'h3000_0000, 16'h00FF, {64'h0, 64'hFFFF_FFFF_FFFF_FFFE}, lat, rd, er, sel, sws, rden);
        chk("wrap_fe", timer_o, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk_o); chk("wrap_ff", timer_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk_o); chk("wrap_0", timer_o, 64'h0);

        @(posedge clk_o); #1;
        m_valid_i = 1; m_addr_i = 32'h8000_0040; m_wstrb_i = 0;
        @(posedge clk_o); #1 m_valid_i = 0;
        repeat (4) @(posedge clk_o);
        #1 rst_n = 0;
        @(posedge clk_o); #1;
        rst_n = 1; m_valid_i = 1; m_addr_i = 32'h1000_0000;
        @(negedge clk_o);
        chk("rst_mtime", timer_o, 0); chk("rst_noready", m_ready_o, 0);
        @(posedge clk_o); #1 m_valid_i = 0;
        @(negedge clk_o);
        chk("rst_accept", m_ready_o, 1); chk("rst_accept_err", m_err_o, 1);
        seen = 0;
        repeat (14) begin
            @(negedge clk_o);
            if (m_ready_o) seen++;
        end
        chk("rst_no_stale", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
